// File: rtl/fir_ctrl_pkg.sv
// Shared types and register-file address map for the FIR sequencing controller.
package fir_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP       = 3'b000,
    OP_COPY      = 3'b001,
    OP_LOAD_SMP  = 3'b010,
    OP_LOAD_COEF = 3'b011,
    OP_ADD       = 3'b100,
    OP_SUB       = 3'b101,
    OP_MUL       = 3'b110
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDC,
    S_STORE,
    S_ZERO,
    S_SHIFT,
    S_MUL,
    S_ACC,
    S_ERR
  } state_t;

  localparam int ACC_ADDR = 0;

  function automatic int new_addr(input int ntaps);
    return ntaps + 1;
  endfunction

  function automatic int tmp_addr(input int ntaps);
    return ntaps + 2;
  endfunction

  function automatic int coef_base(input int ntaps);
    return ntaps + 3;
  endfunction

endpackage

// File: rtl/fir_ctrl_if.sv
// Control bundle between the sample/coefficient handshake, the sequencer and the FIR datapath.
interface fir_ctrl_if #(
  parameter int NTAPS  = 4,
  parameter int ADDR_W = 5
);
  localparam int CIDX_W = $clog2(NTAPS);

  logic                dr;
  logic                lc;
  logic                overflow;
  logic [NTAPS-1:0]    sign_mask;
  logic                cnt_up;
  logic                clear;
  logic                modwait;
  logic [2:0]          op;
  logic [ADDR_W-1:0]   src1;
  logic [ADDR_W-1:0]   src2;
  logic [ADDR_W-1:0]   dest;
  logic [CIDX_W-1:0]   coef_idx;
  logic                done;
  logic                err;

  modport master (
    input  dr, lc, overflow, sign_mask,
    output cnt_up, clear, modwait, op, src1, src2, dest, coef_idx, done, err
  );

  modport slave (
    output dr, lc, overflow, sign_mask,
    input  cnt_up, clear, modwait, op, src1, src2, dest, coef_idx, done, err
  );
endinterface

// File: rtl/fir_tap_counter.sv
// Loadable up/down tap counter; tc flags when the count equals the supplied terminal value.
module fir_tap_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (inc) begin
      count_reg <= count_reg + W'(1);
    end else if (dec) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg == term_val);

endmodule

// File: rtl/fir_ctrl_n.sv
// N-tap FIR sequencer: stores a sample, shifts the delay line, then runs a signed
// multiply-accumulate over all taps; also sequences coefficient loads.
module fir_ctrl_n
  import fir_ctrl_pkg::*;
#(
  parameter int NTAPS  = 4,
  parameter int ADDR_W = 5
) (
  input  logic      clk,
  input  logic      n_rst,
  fir_ctrl_if.master bus
);

  localparam int CIDX_W = $clog2(NTAPS);
  localparam int CNT_W  = $clog2(NTAPS + 1);

  localparam logic [ADDR_W-1:0] ACC_A  = ADDR_W'(ACC_ADDR);
  localparam logic [ADDR_W-1:0] NEW_A  = ADDR_W'(new_addr(NTAPS));
  localparam logic [ADDR_W-1:0] TMP_A  = ADDR_W'(tmp_addr(NTAPS));
  localparam logic [ADDR_W-1:0] COEF_A = ADDR_W'(coef_base(NTAPS));

  localparam logic [CIDX_W-1:0] CIDX_LAST = CIDX_W'(NTAPS - 1);
  localparam logic [CNT_W-1:0]  CNT_N     = CNT_W'(NTAPS);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NTAPS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  generate
    if (NTAPS < 2 || NTAPS > 13) begin : g_bad_ntaps
      $error("fir_ctrl_n: NTAPS must be in 2..13");
    end
    if (2 * NTAPS + 3 > 2 ** ADDR_W) begin : g_bad_addr
      $error("fir_ctrl_n: register map does not fit in ADDR_W");
    end
  endgenerate

  state_t              state_reg, state_next;
  logic                modwait_reg;
  logic [CIDX_W-1:0]   coef_idx_reg;
  logic [NTAPS-1:0]    sign_reg;

  logic                cnt_load, cnt_inc, cnt_dec, cnt_tc;
  logic [CNT_W-1:0]    cnt_load_val, cnt_term, cnt;
  logic [ADDR_W-1:0]   cnt_addr;
  logic [NTAPS-1:0]    tap_sel;
  logic                sign_bit;

  op_t                 op_next;
  logic [ADDR_W-1:0]   src1_next, src2_next, dest_next;
  logic                cnt_up_next, clear_next, done_next, err_next;

  // One counter serves both phases: counts j down in SHIFT, k up in MUL/ACC.
  fir_tap_counter #(.W(CNT_W)) u_tap_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .inc      (cnt_inc),
    .dec      (cnt_dec),
    .term_val (cnt_term),
    .count    (cnt),
    .tc       (cnt_tc)
  );

  assign cnt_term = (state_reg == S_SHIFT) ? CNT_ONE : CNT_LAST;
  assign cnt_addr = ADDR_W'(cnt);

  for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap_sel
    assign tap_sel[gi] = (cnt == CNT_W'(gi));
  end
  assign sign_bit = |(tap_sel & sign_reg);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg    <= S_IDLE;
      modwait_reg  <= 1'b0;
      coef_idx_reg <= '0;
      sign_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      modwait_reg <= (state_next != S_IDLE) && (state_next != S_ERR);
      if (state_reg == S_LDC) begin
        coef_idx_reg <= (coef_idx_reg == CIDX_LAST) ? '0 : coef_idx_reg + CIDX_W'(1);
      end
      // The mask belongs to the sample accepted from IDLE only.
      if (state_reg == S_IDLE && !bus.lc && bus.dr) begin
        sign_reg <= bus.sign_mask;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_inc      = 1'b0;
    cnt_dec      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.lc)      state_next = S_LDC;
        else if (bus.dr) state_next = S_STORE;
      end
      S_LDC:   state_next = S_IDLE;
      S_STORE: state_next = bus.dr ? S_ZERO : S_ERR;
      S_ZERO: begin
        state_next   = S_SHIFT;
        cnt_load     = 1'b1;
        cnt_load_val = CNT_N;
      end
      S_SHIFT: begin
        if (cnt_tc) begin
          state_next   = S_MUL;
          cnt_load     = 1'b1;
          cnt_load_val = '0;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_MUL: state_next = S_ACC;
      S_ACC: begin
        if (bus.overflow) begin
          state_next = S_ERR;
        end else if (cnt_tc) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_MUL;
          cnt_inc    = 1'b1;
        end
      end
      S_ERR: begin
        if (bus.lc)      state_next = S_LDC;
        else if (bus.dr) state_next = S_STORE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    op_next     = OP_NOP;
    src1_next   = '0;
    src2_next   = '0;
    dest_next   = '0;
    cnt_up_next = 1'b0;
    clear_next  = 1'b0;
    done_next   = 1'b0;
    err_next    = 1'b0;
    case (state_reg)
      S_LDC: begin
        op_next    = OP_LOAD_COEF;
        dest_next  = COEF_A + ADDR_W'(coef_idx_reg);
        clear_next = (coef_idx_reg == '0);
      end
      S_STORE: begin
        op_next     = OP_LOAD_SMP;
        dest_next   = NEW_A;
        cnt_up_next = 1'b1;
      end
      S_ZERO: begin
        op_next   = OP_SUB;
        src1_next = ACC_A;
        src2_next = ACC_A;
        dest_next = ACC_A;
      end
      S_SHIFT: begin
        op_next   = OP_COPY;
        src1_next = cnt_tc ? NEW_A : cnt_addr - ADDR_W'(1);
        dest_next = cnt_addr;
      end
      S_MUL: begin
        op_next   = OP_MUL;
        src1_next = cnt_addr + ADDR_W'(1);
        src2_next = COEF_A + cnt_addr;
        dest_next = TMP_A;
      end
      S_ACC: begin
        op_next   = sign_bit ? OP_SUB : OP_ADD;
        src1_next = ACC_A;
        src2_next = TMP_A;
        dest_next = ACC_A;
        done_next = !bus.overflow && cnt_tc;
      end
      S_ERR:   err_next = 1'b1;
      default: ;
    endcase
  end

  assign bus.op       = op_next;
  assign bus.src1     = src1_next;
  assign bus.src2     = src2_next;
  assign bus.dest     = dest_next;
  assign bus.cnt_up   = cnt_up_next;
  assign bus.clear    = clear_next;
  assign bus.done     = done_next;
  assign bus.err      = err_next;
  assign bus.modwait  = modwait_reg;
  assign bus.coef_idx = coef_idx_reg;

endmodule

// File: tb/tb_fir_ctrl_n.sv
// Directed bench for fir_ctrl_n: a 4-tap instance driven from a vector table and
// hand sequences, plus an 8-tap instance for the wider map.
module tb_fir_ctrl_n;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  fir_ctrl_if #(.NTAPS(4), .ADDR_W(5)) ia ();
  fir_ctrl_if #(.NTAPS(8), .ADDR_W(5)) ib ();

  fir_ctrl_n #(.NTAPS(4), .ADDR_W(5)) dut_a (.clk(clk), .n_rst(n_rst), .bus(ia));
  fir_ctrl_n #(.NTAPS(8), .ADDR_W(5)) dut_b (.clk(clk), .n_rst(n_rst), .bus(ib));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       dr;
    logic       lc;
    logic [3:0] sm;
    logic [2:0] op;
    logic [4:0] s1;
    logic [4:0] s2;
    logic [4:0] d;
    logic [4:0] fl;   // {cnt_up, clear, modwait, done, err}
    logic [1:0] ci;
  } vec_t;

  vec_t vecs[26];

  logic [4:0]  fl_a;
  logic [14:0] ad_a;
  logic [21:0] pk_a, pk_b;
  assign fl_a = {ia.cnt_up, ia.clear, ia.modwait, ia.done, ia.err};
  assign ad_a = {ia.src1, ia.src2, ia.dest};
  assign pk_a = {ia.op, ia.src1, ia.src2, ia.dest, ia.cnt_up, ia.done, ia.modwait, ia.err};
  assign pk_b = {ib.op, ib.src1, ib.src2, ib.dest, ib.cnt_up, ib.done, ib.modwait, ib.err};

  function automatic vec_t mk(logic dr, logic lc, logic [3:0] sm, logic [2:0] op,
                              int s1, int s2, int d, logic [4:0] fl, int ci);
    vec_t v;
    v.dr = dr; v.lc = lc; v.sm = sm; v.op = op;
    v.s1 = 5'(s1); v.s2 = 5'(s2); v.d = 5'(d);
    v.fl = fl; v.ci = 2'(ci);
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input int which, input logic dr, input logic lc,
                       input logic ovf, input logic [7:0] sm);
    if (which == 0) begin
      ia.dr = dr; ia.lc = lc; ia.overflow = ovf; ia.sign_mask = sm[3:0];
    end else begin
      ib.dr = dr; ib.lc = lc; ib.overflow = ovf; ib.sign_mask = sm;
    end
  endtask

  // Expected outputs c cycles after the IDLE cycle in which dr is seen.
  function automatic logic [21:0] model(int n, int c, logic [7:0] sm, logic ovf);
    logic [2:0] op;
    logic [7:0] sh;
    int s1, s2, d, j, k, t;
    logic cu, dn, mw;
    op = 3'b000; s1 = 0; s2 = 0; d = 0; cu = 1'b0; dn = 1'b0;
    mw = (c >= 1);
    if (c == 1) begin
      op = 3'b010; d = n + 1; cu = 1'b1;
    end else if (c == 2) begin
      op = 3'b101;
    end else if (c >= 3 && c <= n + 2) begin
      j = n - (c - 3);
      op = 3'b001; d = j; s1 = (j > 1) ? j - 1 : n + 1;
    end else if (c > n + 2) begin
      t = c - (n + 3);
      k = t / 2;
      if (t % 2 == 0) begin
        op = 3'b110; s1 = k + 1; s2 = n + 3 + k; d = n + 2;
      end else begin
        sh = sm >> k;
        op = sh[0] ? 3'b101 : 3'b100;
        s2 = n + 2;
        dn = (k == n - 1) && !ovf;
      end
    end
    return {op, 5'(s1), 5'(s2), 5'(d), cu, dn, mw, 1'b0};
  endfunction

  task automatic run_sample(input int which, input logic [7:0] sm, input int ovf_c,
                            input int lc_lo, input int lc_hi, input int last_c,
                            input string tag);
    int n;
    n = (which == 0) ? 4 : 8;
    for (int c = 0; c <= last_c; c++) begin
      drive(which, c <= 1, (c >= lc_lo && c <= lc_hi), c == ovf_c, sm);
      check(tag, c, 32'((which == 0) ? pk_a : pk_b), 32'(model(n, c, sm, c == ovf_c)));
      @(negedge clk);
    end
    drive(which, 1'b0, 1'b0, 1'b0, sm);
  endtask

  initial begin
    // coefficient loads, one full sample, then lc+dr together in IDLE
    vecs[0]  = mk(0, 1, 4'b0000, 3'd0, 0, 0, 0,  5'b00000, 0);
    vecs[1]  = mk(0, 0, 4'b0000, 3'd3, 0, 0, 7,  5'b01100, 0);
    vecs[2]  = mk(0, 1, 4'b0000, 3'd0, 0, 0, 0,  5'b00000, 1);
    vecs[3]  = mk(0, 0, 4'b0000, 3'd3, 0, 0, 8,  5'b00100, 1);
    vecs[4]  = mk(0, 1, 4'b0000, 3'd0, 0, 0, 0,  5'b00000, 2);
    vecs[5]  = mk(0, 0, 4'b0000, 3'd3, 0, 0, 9,  5'b00100, 2);
    vecs[6]  = mk(0, 1, 4'b0000, 3'd0, 0, 0, 0,  5'b00000, 3);
    vecs[7]  = mk(0, 0, 4'b0000, 3'd3, 0, 0, 10, 5'b00100, 3);
    vecs[8]  = mk(1, 0, 4'b0101, 3'd0, 0, 0, 0,  5'b00000, 0);
    vecs[9]  = mk(1, 0, 4'b0101, 3'd2, 0, 0, 5,  5'b10100, 0);
    vecs[10] = mk(0, 0, 4'b0000, 3'd5, 0, 0, 0,  5'b00100, 0);
    vecs[11] = mk(0, 0, 4'b0000, 3'd1, 3, 0, 4,  5'b00100, 0);
    vecs[12] = mk(0, 0, 4'b0000, 3'd1, 2, 0, 3,  5'b00100, 0);
    vecs[13] = mk(0, 0, 4'b0000, 3'd1, 1, 0, 2,  5'b00100, 0);
    vecs[14] = mk(0, 0, 4'b0000, 3'd1, 5, 0, 1,  5'b00100, 0);
    vecs[15] = mk(0, 0, 4'b0000, 3'd6, 1, 7, 6,  5'b00100, 0);
    vecs[16] = mk(0, 0, 4'b0000, 3'd5, 0, 6, 0,  5'b00100, 0);
    vecs[17] = mk(0, 0, 4'b0000, 3'd6, 2, 8, 6,  5'b00100, 0);
    vecs[18] = mk(0, 0, 4'b0000, 3'd4, 0, 6, 0,  5'b00100, 0);
    vecs[19] = mk(0, 0, 4'b0000, 3'd6, 3, 9, 6,  5'b00100, 0);
    vecs[20] = mk(0, 0, 4'b0000, 3'd5, 0, 6, 0,  5'b00100, 0);
    vecs[21] = mk(0, 0, 4'b0000, 3'd6, 4, 10, 6, 5'b00100, 0);
    vecs[22] = mk(0, 0, 4'b0000, 3'd4, 0, 6, 0,  5'b00110, 0);
    vecs[23] = mk(1, 1, 4'b0000, 3'd0, 0, 0, 0,  5'b00000, 0);
    vecs[24] = mk(0, 0, 4'b0000, 3'd3, 0, 0, 7,  5'b01100, 0);
    vecs[25] = mk(0, 0, 4'b0000, 3'd0, 0, 0, 0,  5'b00000, 1);

    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_flags", 0, 32'(fl_a), 32'(0));
    check("reset_op", 0, 32'(ia.op), 32'(0));
    check("reset_cidx", 0, 32'(ia.coef_idx), 32'(0));
    n_rst = 1'b1;

    for (int i = 0; i < 26; i++) begin
      drive(0, vecs[i].dr, vecs[i].lc, 1'b0, {4'b0000, vecs[i].sm});
      check("vec_op", i, 32'(ia.op), 32'(vecs[i].op));
      check("vec_addr", i, 32'(ad_a), 32'({vecs[i].s1, vecs[i].s2, vecs[i].d}));
      check("vec_flags", i, 32'(fl_a), 32'(vecs[i].fl));
      check("vec_cidx", i, 32'(ia.coef_idx), 32'(vecs[i].ci));
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);

    // dr dropped during STORE, recovery via dr, then via lc
    drive(0, 1'b1, 1'b0, 1'b0, 8'h00); @(negedge clk);
    check("t3_store_op", 0, 32'(ia.op), 32'(2));
    check("t3_cnt_up", 0, 32'(ia.cnt_up), 32'(1));
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00); @(negedge clk);
    check("t3_err", 0, 32'(ia.err), 32'(1));
    check("t3_err_op", 0, 32'(ia.op), 32'(0));
    check("t3_cnt_up_once", 0, 32'(ia.cnt_up), 32'(0));
    check("t3_err_modwait", 0, 32'(ia.modwait), 32'(0));
    drive(0, 1'b1, 1'b0, 1'b0, 8'h00); @(negedge clk);
    check("t3_restore_err", 0, 32'(ia.err), 32'(0));
    check("t3_restore_op", 0, 32'(ia.op), 32'(2));
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00); @(negedge clk);
    check("t3_err2", 0, 32'(ia.err), 32'(1));
    drive(0, 1'b0, 1'b1, 1'b0, 8'h00); @(negedge clk);
    check("t3_ldc", 0, 32'({ia.op, ia.dest, ia.err}), 32'({3'd3, 5'd8, 1'b0}));
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00); @(negedge clk);
    check("t3_idle", 0, 32'({ia.op, ia.modwait}), 32'(0));
    check("t3_cidx", 0, 32'(ia.coef_idx), 32'(2));

    // overflow on the second ACC
    run_sample(0, 8'h02, 10, -1, -2, 10, "t4_sample");
    check("t4_err", 0, 32'({ia.err, ia.done, ia.op}), 32'({1'b1, 1'b0, 3'd0}));
    drive(0, 1'b0, 1'b1, 1'b0, 8'h00); @(negedge clk);
    check("t4_ldc", 0, 32'({ia.op, ia.dest, ia.err}), 32'({3'd3, 5'd9, 1'b0}));
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00); @(negedge clk);
    check("t4_idle", 0, 32'({ia.op, ia.modwait, ia.coef_idx}), 32'({3'd0, 1'b0, 2'd3}));

    // lc held through MUL/ACC is ignored
    run_sample(0, 8'h00, -1, 7, 13, 14, "t5_lc_busy");
    check("t5_idle", 0, 32'({ia.op, ia.modwait, ia.coef_idx}), 32'({3'd0, 1'b0, 2'd3}));
    @(negedge clk);
    check("t5_no_ldc", 0, 32'(ia.op), 32'(0));

    // asynchronous reset in the middle of SHIFT
    run_sample(0, 8'h0F, -1, -1, -2, 4, "t6_pre");
    #2 n_rst = 1'b0;
    #1;
    check("t6_rst_addr", 0, 32'({ia.op, ad_a}), 32'(0));
    check("t6_rst_flags", 0, 32'(fl_a), 32'(0));
    check("t6_rst_cidx", 0, 32'(ia.coef_idx), 32'(0));
    @(negedge clk);
    n_rst = 1'b1;
    run_sample(0, 8'h0A, -1, -1, -2, 14, "t6_post");
    check("t6_post_idle", 0, 32'({ia.op, ia.modwait}), 32'(0));

    // 8-tap instance: coefficient map up to C[7]=18, then a full sample
    for (int i = 0; i < 8; i++) begin
      drive(1, 1'b0, 1'b1, 1'b0, 8'h00); @(negedge clk);
      check("b_ldc_op", i, 32'(ib.op), 32'(3));
      check("b_ldc_dest", i, 32'(ib.dest), 32'(11 + i));
      check("b_ldc_clear", i, 32'(ib.clear), 32'(i == 0));
      drive(1, 1'b0, 1'b0, 1'b0, 8'h00); @(negedge clk);
    end
    check("b_cidx_wrap", 0, 32'(ib.coef_idx), 32'(0));
    run_sample(1, 8'b1000_0001, -1, -1, -2, 26, "b_sample");
    check("b_idle", 0, 32'({ib.op, ib.modwait}), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
